uc_arbiter: RTL

Unit-clause arbiter sitting between the NUM_ENGINE BCP engines and the global state table (GST). It accepts implied unit literals from the engines by round-robin arbitration and queues them in a central FIFO. It drops duplicates and detects conflicting assignments through a pending-variable scoreboard. It is the writer side of the GST update interface, presenting one literal per cycle (or the initial decision) and retiring it on the GST's pop.

---
 rtl/uc_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/uc_arbiter.sv
// rtl/uc_arbiter.sv - round-robin unit-literal arbiter feeding the GST through a central FIFO
// Drops duplicates and flags opposite-polarity assignments via a per-variable pending scoreboard.
module uc_arbiter #(
   parameter int NUM_ENGINE = 4,
   parameter int LIT_W      = 8,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic [NUM_ENGINE*LIT_W-1:0]          bcp2ucarb_lit,
   input  logic [NUM_ENGINE-1:0]                bcp2ucarb_valid,
   output logic [NUM_ENGINE-1:0]                ucarb2bcp_ack,
   input  logic [LIT_W-1:0]                     dec2ucarb_lit,
   input  logic                                 dec2ucarb_valid,
   output logic                                 ucarb2dec_ack,
   output logic [LIT_W-1:0]                     ucarb2gst_lit,
   output logic                                 ucarb2gst_valid,
   output logic [LIT_W-1:0]                     ucarb2gst_init_lit,
   output logic                                 ucarb2gst_init_vaild,
   input  logic                                 gst2ucarb_pop,
   output logic                                 conflict,
   input  logic                                 conflict_clr,
   output logic [$clog2(FIFO_DEPTH):0]          occupancy,
   output logic                                 idle
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int VAR_W = LIT_W - 1;
   localparam int NVAR  = 1 << VAR_W;
   localparam int RR_W  = (NUM_ENGINE > 1) ? $clog2(NUM_ENGINE) : 1;

   typedef enum logic {RUN = 1'b0, CONFLICT = 1'b1} state_t;

   state_t               state_q, state_d;
   logic [RR_W-1:0]      rr_q, grant_idx;
   logic                 grant_found, grant, run, empty, full, any_valid;
   logic                 g_null, g_pend, g_same_pol, enq, hit_conflict, pop_fire;
   logic [LIT_W-1:0]     g_lit, g_neg, head_lit, head_neg;
   logic [VAR_W-1:0]     g_var, head_var;
   logic [NVAR-1:0]      sb_pend_q, sb_pol_q;
   logic [LIT_W-1:0]     fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]     count_q;

   assign run       = (state_q == RUN);
   assign empty     = (count_q == '0);
   assign full      = (count_q == CNT_W'(FIFO_DEPTH));
   assign any_valid = |bcp2ucarb_valid;

   // First valid engine at or after the RR pointer.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int i = 0; i < NUM_ENGINE; i++) begin
         if (!grant_found && bcp2ucarb_valid[(int'(rr_q) + i) % NUM_ENGINE]) begin
            grant_found = 1'b1;
            grant_idx   = RR_W'((int'(rr_q) + i) % NUM_ENGINE);
         end
      end
   end

   assign grant = rst_n && grant_found && run && !full && !conflict_clr;

   always_comb begin
      ucarb2bcp_ack = '0;
      if (grant) ucarb2bcp_ack[grant_idx] = 1'b1;
   end

   assign g_lit      = bcp2ucarb_lit[int'(grant_idx)*LIT_W +: LIT_W];
   assign g_neg      = -g_lit;
   assign g_var      = g_lit[LIT_W-1] ? g_neg[VAR_W-1:0] : g_lit[VAR_W-1:0];
   assign g_null     = (g_lit == '0);
   assign g_pend     = sb_pend_q[g_var];
   assign g_same_pol = (sb_pol_q[g_var] == g_lit[LIT_W-1]);

   // Scoreboard lookup sees pre-pop state, so a popping variable still catches its opposite.
   assign enq          = grant && !g_null && !g_pend;
   assign hit_conflict = grant && !g_null && g_pend && !g_same_pol;

   assign head_lit = fifo_mem[rd_ptr_q];
   assign head_neg = -head_lit;
   assign head_var = head_lit[LIT_W-1] ? head_neg[VAR_W-1:0] : head_lit[VAR_W-1:0];

   assign ucarb2gst_valid      = !empty && run;
   assign ucarb2gst_lit        = ucarb2gst_valid ? head_lit : '0;
   assign pop_fire             = ucarb2gst_valid && gst2ucarb_pop && !conflict_clr;
   assign ucarb2gst_init_vaild = dec2ucarb_valid && empty && run && !any_valid;
   assign ucarb2gst_init_lit   = ucarb2gst_init_vaild ? dec2ucarb_lit : '0;
   assign ucarb2dec_ack        = ucarb2gst_init_vaild && gst2ucarb_pop;

   assign conflict  = (state_q == CONFLICT);
   assign occupancy = count_q;
   assign idle      = empty && !any_valid && !dec2ucarb_valid && run;

   always_comb begin
      state_d = state_q;
      if (conflict_clr)      state_d = RUN;
      else if (hit_conflict) state_d = CONFLICT;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= RUN;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (!rst_n)     rr_q <= '0;
      else if (grant) rr_q <= RR_W'((int'(grant_idx) + 1) % NUM_ENGINE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n || conflict_clr) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         sb_pend_q <= '0;
         sb_pol_q  <= '0;
      end else begin
         if (enq)      wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_fire) rd_ptr_q <= rd_ptr_q + 1'b1;
         if (enq && !pop_fire)      count_q <= count_q + 1'b1;
         else if (!enq && pop_fire) count_q <= count_q - 1'b1;
         // Set is written after clear so a same-variable enqueue wins over the pop.
         if (pop_fire) sb_pend_q[head_var] <= 1'b0;
         if (enq) begin
            sb_pend_q[g_var] <= 1'b1;
            sb_pol_q[g_var]  <= g_lit[LIT_W-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (enq) fifo_mem[wr_ptr_q] <= g_lit;
   end

endmodule
